// File: rtl/downsampler_window_gen_fp_if.sv
// Stream bus for downsampler_window_gen_fp: tagged FP pixel input side, block window output side.
// master drives pixels/frame size; slave (the downsampler) drives windows.
interface downsampler_window_gen_fp_if #(
   parameter int EXP_WIDTH  = 5,
   parameter int FRAC_WIDTH = 10,
   parameter int FACTOR     = 2
);
   localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH;

   logic [15:0]                                       width_i;
   logic [15:0]                                       height_i;
   logic [FP_WIDTH_REG-1:0]                           pixel_i;
   logic [15:0]                                       col_i;
   logic [15:0]                                       row_i;
   logic                                              valid_i;
   logic [FACTOR-1:0][FACTOR-1:0][FP_WIDTH_REG-1:0]   window_o;
   logic [15:0]                                       col_o;
   logic [15:0]                                       row_o;
   logic                                              valid_o;

   modport master (
      output width_i, height_i, pixel_i, col_i, row_i, valid_i,
      input  window_o, col_o, row_o, valid_o
   );

   modport slave (
      input  width_i, height_i, pixel_i, col_i, row_i, valid_i,
      output window_o, col_o, row_o, valid_o
   );
endinterface

// File: rtl/downsampler_window_gen_fp.sv
// Raster-stream front end: buffers FACTOR-1 lines and emits block-aligned FACTOR x FACTOR FP windows.
// Define DS_EDGE_REPLICATE_EN to also emit right/bottom partial blocks with edge replication.
module downsampler_window_gen_fp #(
   parameter int EXP_WIDTH    = 5,
   parameter int FRAC_WIDTH   = 10,
   parameter int FACTOR       = 2,
   parameter int MAX_WIDTH    = 1024,
   parameter int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   downsampler_window_gen_fp_if.slave bus
);
   localparam int          LOGF    = $clog2(FACTOR);
   localparam int          NWORDS  = (MAX_WIDTH + FACTOR - 1) / FACTOR;
   localparam int          AW      = $clog2(NWORDS);
   localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);

   typedef logic [FACTOR-1:0][FP_WIDTH_REG-1:0] row_t;
   typedef logic [FACTOR-1:0][FACTOR-1:0][FP_WIDTH_REG-1:0] win_t;

   logic [15:0] r_width;
   logic [15:0] r_height;
   row_t        r_cur;
   // Each line-buffer word holds one block-column of a stored row, so a window row is one read.
   row_t        r_line [FACTOR-1][NWORDS];
   win_t        r_window;
   logic [15:0] r_col_o;
   logic [15:0] r_row_o;
   logic        r_valid_o;

   logic            w_start;
   logic            w_accept;
   logic            w_emit;
   logic            w_col_end;
   logic            w_row_end;
   logic [15:0]     w_width_clamp;
   logic [15:0]     w_width;
   logic [15:0]     w_height;
   logic [15:0]     w_col_blk;
   logic [15:0]     w_row_blk;
   logic [LOGF-1:0] w_col_lane;
   logic [LOGF-1:0] w_row_lane;
   logic [AW-1:0]   w_addr;
   row_t            w_cur_next;
   row_t            w_cur_row;
   row_t            w_slot_rd [FACTOR-1];
   win_t            w_window;

   assign w_start       = bus.valid_i && (bus.col_i == 16'd0) && (bus.row_i == 16'd0);
   assign w_width_clamp = (bus.width_i > MAX_W16) ? MAX_W16 : bus.width_i;
   // The (0,0) pixel itself is judged against the size it carries.
   assign w_width       = w_start ? w_width_clamp : r_width;
   assign w_height      = w_start ? bus.height_i  : r_height;
   assign w_accept      = bus.valid_i && (bus.col_i < w_width) && (bus.row_i < w_height);

   assign w_col_blk  = bus.col_i >> LOGF;
   assign w_row_blk  = bus.row_i >> LOGF;
   assign w_col_lane = bus.col_i[LOGF-1:0];
   assign w_row_lane = bus.row_i[LOGF-1:0];
   assign w_addr     = w_col_blk[AW-1:0];

`ifdef DS_EDGE_REPLICATE_EN
   assign w_col_end = (&w_col_lane) || (bus.col_i == w_width - 16'd1);
   assign w_row_end = (&w_row_lane) || (bus.row_i == w_height - 16'd1);
`else
   assign w_col_end = &w_col_lane;
   assign w_row_end = &w_row_lane;
`endif
   assign w_emit = w_accept && w_col_end && w_row_end;

   always_comb begin
      w_cur_next             = (w_col_lane == '0) ? '0 : r_cur;
      w_cur_next[w_col_lane] = bus.pixel_i;
   end

   always_comb begin
      for (int k = 0; k < FACTOR - 1; k++) begin
         w_slot_rd[k] = r_line[k][w_addr];
      end
   end

   always_comb begin
      w_cur_row             = r_cur;
      w_cur_row[w_col_lane] = bus.pixel_i;
      w_window              = '0;
      for (int k = 0; k < FACTOR - 1; k++) begin
         w_window[k] = w_slot_rd[k];
      end
      w_window[FACTOR-1] = w_cur_row;
`ifdef DS_EDGE_REPLICATE_EN
      // Columns past the right edge copy the last valid column; rows past the bottom copy the current row.
      for (int j = 0; j < FACTOR; j++) begin
         if (LOGF'(j) > w_col_lane) w_cur_row[j] = bus.pixel_i;
      end
      for (int k = 0; k < FACTOR - 1; k++) begin
         for (int j = 0; j < FACTOR; j++) begin
            if (LOGF'(j) > w_col_lane) w_window[k][j] = w_slot_rd[k][w_col_lane];
         end
      end
      for (int k = 0; k < FACTOR; k++) begin
         if (LOGF'(k) >= w_row_lane) w_window[k] = w_cur_row;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_width   <= '0;
         r_height  <= '0;
         r_cur     <= '0;
         r_window  <= '0;
         r_col_o   <= '0;
         r_row_o   <= '0;
         r_valid_o <= 1'b0;
      end else begin
         r_valid_o <= w_emit;
         if (w_start) begin
            r_width  <= w_width_clamp;
            r_height <= bus.height_i;
         end
         if (w_accept) begin
            r_cur <= w_cur_next;
         end
         if (w_emit) begin
            r_window <= w_window;
            r_col_o  <= w_col_blk;
            r_row_o  <= w_row_blk;
         end
      end
   end

   // Line storage is never cleared; emission always needs the block's upper rows written first.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         for (int s = 0; s < FACTOR - 1; s++) begin
            if (w_row_lane == LOGF'(s)) r_line[s][w_addr][w_col_lane] <= bus.pixel_i;
         end
      end
   end

   assign bus.window_o = r_window;
   assign bus.col_o    = r_col_o;
   assign bus.row_o    = r_row_o;
   assign bus.valid_o  = r_valid_o;
endmodule

// File: tb/tb_downsampler_window_gen_fp.sv
// Bench for downsampler_window_gen_fp: F=2 and F=4 instances, expected windows queued at drive time.
// Edge-replicate expectations follow the DS_EDGE_REPLICATE_EN macro of the build.
module tb_downsampler_window_gen_fp;
   localparam int MW2 = 32;
   localparam int MW4 = 64;
`ifdef DS_EDGE_REPLICATE_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   typedef struct {
      logic [255:0] win;
      logic [15:0]  col;
      logic [15:0]  row;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   n_out2 = 0;
   int   n_out4 = 0;
   int   last_col2 = -1;
   int   base;
   exp_t q2[$];
   exp_t q4[$];
   exp_t e2;
   exp_t e4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   downsampler_window_gen_fp_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .FACTOR(2)) if2 ();
   downsampler_window_gen_fp_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .FACTOR(4)) if4 ();

   downsampler_window_gen_fp #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .FACTOR(2), .MAX_WIDTH(MW2)) u_dut2 (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (if2)
   );

   downsampler_window_gen_fp #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .FACTOR(4), .MAX_WIDTH(MW4)) u_dut4 (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (if4)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fp16(input int n);
      int         e;
      logic [15:0] m;
      if (n == 0) return 16'h0000;
      e = 0;
      for (int i = 0; i < 11; i++) if (n >= (1 << i)) e = i;
      m = 16'(n << (10 - e));
      return {1'b0, 5'(e + 15), m[9:0]};
   endfunction

   function automatic logic [255:0] model_win(input int f, input int r, input int c, input int wpix);
      logic [255:0] w;
      int rb, cb, rr, cc;
      w  = '0;
      rb = r - (r % f);
      cb = c - (c % f);
      for (int k = 0; k < f; k++) begin
         for (int j = 0; j < f; j++) begin
            rr = rb + ((k < r % f) ? k : r % f);
            cc = cb + ((j < c % f) ? j : c % f);
            w[(k * f + j) * 16 +: 16] = fp16(rr * wpix + cc);
         end
      end
      return w;
   endfunction

   task automatic set_in(input int inst, input bit v, input int w, input int h, input int r, input int c);
      if (inst == 2) begin
         if2.valid_i  = v;
         if2.width_i  = 16'(w);
         if2.height_i = 16'(h);
         if2.row_i    = 16'(r);
         if2.col_i    = 16'(c);
         if2.pixel_i  = fp16(r * w + c);
      end else begin
         if4.valid_i  = v;
         if4.width_i  = 16'(w);
         if4.height_i = 16'(h);
         if4.row_i    = 16'(r);
         if4.col_i    = 16'(c);
         if4.pixel_i  = fp16(r * w + c);
      end
   endtask

   task automatic drive_frame(input int inst, input int w_in, input int h, input int bub, input bit kill_last);
      int   f, weff;
      exp_t e;
      f    = (inst == 2) ? 2 : 4;
      weff = (inst == 2) ? ((w_in > MW2) ? MW2 : w_in) : ((w_in > MW4) ? MW4 : w_in);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w_in; c++) begin
            for (int b = 0; b < 8 && $urandom_range(0, 99) < bub; b++) begin
               set_in(inst, 1'b0, w_in, h, r, c);
               @(posedge clk); #1;
            end
            set_in(inst, 1'b1, w_in, h, r, c);
            if (kill_last && r == h - 1 && c == w_in - 1) begin
               rst_n = 1'b0;
            end else if (c < weff && ((c % f == f - 1) || (REP && c == weff - 1)) &&
                         ((r % f == f - 1) || (REP && r == h - 1))) begin
               e.win = model_win(f, r, c, w_in);
               e.col = 16'(c / f);
               e.row = 16'(r / f);
               e.cyc = cyc + 1;
               if (inst == 2) q2.push_back(e);
               else q4.push_back(e);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      end
      set_in(inst, 1'b0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (if2.valid_o === 1'b1) begin
         n_out2++;
         last_col2 = int'(if2.col_o);
         chk("f2_expected_any", 256'(q2.size() > 0), 256'(1));
         if (q2.size() > 0) begin
            e2 = q2.pop_front();
            chk("f2_window", 256'(if2.window_o), e2.win);
            chk("f2_col_o", 256'(if2.col_o), 256'(e2.col));
            chk("f2_row_o", 256'(if2.row_o), 256'(e2.row));
            chk("f2_latency", 256'(cyc), 256'(e2.cyc));
         end
      end
      if (if4.valid_o === 1'b1) begin
         n_out4++;
         chk("f4_expected_any", 256'(q4.size() > 0), 256'(1));
         if (q4.size() > 0) begin
            e4 = q4.pop_front();
            chk("f4_window", 256'(if4.window_o), e4.win);
            chk("f4_col_o", 256'(if4.col_o), 256'(e4.col));
            chk("f4_row_o", 256'(if4.row_o), 256'(e4.row));
            chk("f4_latency", 256'(cyc), 256'(e4.cyc));
         end
      end
   end

   task automatic drain(input string tag);
      repeat (3) @(posedge clk);
      #1;
      chk(tag, 256'(q2.size() + q4.size()), 256'(0));
   endtask

   initial begin
      set_in(2, 1'b0, 0, 0, 0, 0);
      set_in(4, 1'b0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid2", 256'(if2.valid_o), 256'(0));
      chk("rst_window2", 256'(if2.window_o), 256'(0));
      chk("rst_col2", 256'(if2.col_o), 256'(0));
      chk("rst_row2", 256'(if2.row_o), 256'(0));
      chk("rst_valid4", 256'(if4.valid_o), 256'(0));
      chk("rst_window4", 256'(if4.window_o), 256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 4x4 F=2: top-left block is {{0,1},{4,5}}
      base = n_out2;
      drive_frame(2, 4, 4, 0, 1'b0);
      drain("t1_drain");
      chk("t1_count", 256'(n_out2 - base), 256'(4));
      chk("t1_tl_ref", model_win(2, 1, 1, 4), {192'b0, fp16(5), fp16(4), fp16(1), fp16(0)});

      // 8x4 F=4 without then with bubbles
      base = n_out4;
      drive_frame(4, 8, 4, 0, 1'b0);
      drain("t2a_drain");
      chk("t2a_count", 256'(n_out4 - base), 256'(2));
      base = n_out4;
      drive_frame(4, 8, 4, 50, 1'b0);
      drain("t2b_drain");
      chk("t2b_count", 256'(n_out4 - base), 256'(2));

      // 5x3 F=2 partial blocks
      base = n_out2;
      drive_frame(2, 5, 3, 0, 1'b0);
      drain("t3_drain");
      chk("t3_count", 256'(n_out2 - base), REP ? 256'(6) : 256'(2));

      // reset at completing pixel of block (1,1), then full restart
      base = n_out2;
      drive_frame(2, 4, 4, 0, 1'b1);
      chk("t4_valid_after_rst", 256'(if2.valid_o), 256'(0));
      @(negedge clk);
      chk("t4_valid_next", 256'(if2.valid_o), 256'(0));
      @(posedge clk); #1;
      drain("t4_drain_killed");
      chk("t4_killed_count", 256'(n_out2 - base), 256'(3));
      base = n_out2;
      drive_frame(2, 4, 4, 0, 1'b0);
      drain("t4_drain_restart");
      chk("t4_restart_count", 256'(n_out2 - base), 256'(4));

      // back-to-back frames 4x4 then 6x2
      base = n_out2;
      drive_frame(2, 4, 4, 0, 1'b0);
      drive_frame(2, 6, 2, 0, 1'b0);
      drain("t5_drain");
      chk("t5_count", 256'(n_out2 - base), 256'(7));
      chk("t5_last_col", 256'(last_col2), 256'(2));

      // width beyond line buffer depth
      base = n_out2;
      drive_frame(2, MW2 + 8, 2, 0, 1'b0);
      drain("t6_drain");
      chk("t6_count", 256'(n_out2 - base), 256'(MW2 / 2));
      chk("t6_last_col", 256'(last_col2), 256'(MW2 / 2 - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
